// File: rtl/key_vault_pkg.sv
// Shared types and mixing helpers for the multi-slot DNA-bound key vault.
package key_vault_pkg;

    localparam int KV_KEY_WIDTH = 128;
    localparam int KV_DNA_WIDTH = 57;
    localparam int ROT_L        = 13;
    localparam int SHR          = 7;

    typedef enum logic [2:0] {
        S_READ   = 3'd0,
        S_CHECK  = 3'd1,
        S_READY  = 3'd2,
        S_DERIVE = 3'd3,
        S_ZERO   = 3'd4,
        S_LOCKED = 3'd5
    } kv_state_e;

    // DNA repeated from bit 0 upward, upper copy truncated at the key width.
    function automatic logic [KV_KEY_WIDTH-1:0] dna_expand(input logic [KV_DNA_WIDTH-1:0] dna);
        logic [KV_KEY_WIDTH-1:0] d;
        for (int i = 0; i < KV_KEY_WIDTH; i++) begin
            d[i] = dna[i % KV_DNA_WIDTH];
        end
        return d;
    endfunction

    function automatic logic [KV_KEY_WIDTH-1:0] kv_mix_round(input logic [KV_KEY_WIDTH-1:0] x,
                                                             input logic [KV_KEY_WIDTH-1:0] d,
                                                             input logic [7:0]              i);
        return ((x << ROT_L) | (x >> (KV_KEY_WIDTH - ROT_L))) ^ (x >> SHR) ^ d
               ^ {(KV_KEY_WIDTH / 8){i}};
    endfunction

endpackage

// File: rtl/dna_reader.sv
// DNA_PORT read/shift sequencer and capture shift register; runs while start is held.
module dna_reader #(
    parameter int DNA_WIDTH = 57
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 dna_dout,
    output logic                 dna_read,
    output logic                 dna_shift,
    output logic                 done,
    output logic [DNA_WIDTH-1:0] dna
);
    localparam int CNT_W = $clog2(DNA_WIDTH);

    logic [CNT_W-1:0]     bit_cnt;
    logic [DNA_WIDTH-1:0] dna_sr;

    // Asserted during the cycle whose closing edge captures the final bit.
    assign done = dna_shift && (bit_cnt == CNT_W'(DNA_WIDTH - 1));
    assign dna  = dna_sr;

    always_ff @(posedge clk) begin
        if (rst) begin
            dna_read  <= 1'b0;
            dna_shift <= 1'b0;
            bit_cnt   <= '0;
            dna_sr    <= '0;
        end else if (!start) begin
            dna_read  <= 1'b0;
            dna_shift <= 1'b0;
            bit_cnt   <= '0;
        end else if (dna_read) begin
            dna_read  <= 1'b0;
            dna_shift <= 1'b1;
        end else if (dna_shift) begin
            dna_sr <= {dna_sr[DNA_WIDTH-2:0], dna_dout};
            if (done) begin
                dna_shift <= 1'b0;
            end else begin
                bit_cnt <= bit_cnt + 1'b1;
            end
        end else begin
            dna_read <= 1'b1;
            bit_cnt  <= '0;
        end
    end

endmodule

// File: rtl/key_vault_mslot.sv
// Multi-slot DNA-bound key vault: DNA verification, write-only slots, per-slot key derivation.
//   state    | meaning
//   S_READ   | reading device DNA from DNA_PORT
//   S_CHECK  | compare captured DNA with golden
//   S_READY  | accept key writes and derive requests
//   S_DERIVE | one mix round per cycle
//   S_ZERO   | clear one slot per cycle
//   S_LOCKED | terminal until reset
module key_vault_mslot
    import key_vault_pkg::*;
#(
    parameter int  KEY_WIDTH  = KV_KEY_WIDTH,
    parameter int  DNA_WIDTH  = KV_DNA_WIDTH,
    parameter int  NUM_SLOTS  = 4,
    parameter int  MIX_ROUNDS = 4,
    parameter int  MAX_FAIL   = 3,
    localparam int SLOT_W     = $clog2(NUM_SLOTS)
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 dna_read,
    output logic                 dna_shift,
    input  logic                 dna_dout,
    input  logic [DNA_WIDTH-1:0] golden_dna,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic [SLOT_W-1:0]    wr_slot,
    input  logic [KEY_WIDTH-1:0] wr_key,
    input  logic                 rd_req,
    input  logic [SLOT_W-1:0]    rd_slot,
    output logic [KEY_WIDTH-1:0] key_out,
    output logic                 key_valid,
    output logic                 key_err,
    input  logic                 tamper_in,
    input  logic                 zeroize_req,
    output logic [2:0]           state_out,
    output logic                 system_locked,
    output logic [NUM_SLOTS-1:0] slot_valid,
    output logic [1:0]           fail_count,
    output logic [DNA_WIDTH-1:0] device_dna
);
    kv_state_e            state;
    logic [KEY_WIDTH-1:0] slots [NUM_SLOTS];
    logic [KEY_WIDTH-1:0] mix_x;
    logic [KEY_WIDTH-1:0] dna_key;
    logic [7:0]           round;
    logic [SLOT_W-1:0]    zero_idx;
    logic                 zero_tamper;
    logic                 dna_ok;
    logic                 abort;
    logic [1:0]           fail_next;
    logic                 rdr_done;
    logic [DNA_WIDTH-1:0] rdr_dna;

    dna_reader #(.DNA_WIDTH(DNA_WIDTH)) u_dna_reader (
        .clk       (clk),
        .rst       (rst),
        .start     (state == S_READ),
        .dna_dout  (dna_dout),
        .dna_read  (dna_read),
        .dna_shift (dna_shift),
        .done      (rdr_done),
        .dna       (rdr_dna)
    );

    assign dna_key       = dna_expand(device_dna);
    assign abort         = tamper_in | zeroize_req;
    assign fail_next     = (fail_count == 2'd3) ? 2'd3 : fail_count + 2'd1;
    assign state_out     = state;
    assign system_locked = (state == S_LOCKED);
    // Ready drops whenever a read or zeroize claims this cycle, so valid&ready always means stored.
    assign wr_ready      = (state == S_READY) && !rd_req && !abort;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_READ;
            for (int i = 0; i < NUM_SLOTS; i++) slots[i] <= '0;
            slot_valid  <= '0;
            fail_count  <= '0;
            device_dna  <= '0;
            mix_x       <= '0;
            round       <= '0;
            zero_idx    <= '0;
            zero_tamper <= 1'b0;
            dna_ok      <= 1'b0;
            key_out     <= '0;
            key_valid   <= 1'b0;
            key_err     <= 1'b0;
        end else begin
            key_out   <= '0;
            key_valid <= 1'b0;
            key_err   <= 1'b0;
            if (abort && state != S_LOCKED && state != S_ZERO) begin
                state       <= S_ZERO;
                zero_idx    <= '0;
                zero_tamper <= tamper_in;
                mix_x       <= '0;
                round       <= '0;
            end else begin
                case (state)
                    S_READ: if (rdr_done) state <= S_CHECK;
                    S_CHECK: begin
                        if (rdr_dna == golden_dna || golden_dna == '0) begin
                            device_dna <= rdr_dna;
                            dna_ok     <= 1'b1;
                            state      <= S_READY;
                        end else begin
                            fail_count <= fail_next;
                            state      <= (int'(fail_next) >= MAX_FAIL) ? S_LOCKED : S_READ;
                        end
                    end
                    S_READY: begin
                        if (rd_req) begin
                            if (slot_valid[rd_slot]) begin
                                mix_x <= slots[rd_slot] ^ dna_key
                                         ^ {rd_slot, {(KEY_WIDTH - SLOT_W){1'b0}}};
                                round <= '0;
                                state <= S_DERIVE;
                            end else begin
                                key_err <= 1'b1;
                            end
                        end else if (wr_valid) begin
                            slots[wr_slot]      <= wr_key;
                            slot_valid[wr_slot] <= 1'b1;
                        end
                    end
                    S_DERIVE: begin
                        if (round == 8'(MIX_ROUNDS - 1)) begin
                            key_out   <= kv_mix_round(mix_x, dna_key, round);
                            key_valid <= 1'b1;
                            mix_x     <= '0;
                            round     <= '0;
                            state     <= S_READY;
                        end else begin
                            mix_x <= kv_mix_round(mix_x, dna_key, round);
                            round <= round + 8'd1;
                        end
                    end
                    S_ZERO: begin
                        slots[zero_idx]      <= '0;
                        slot_valid[zero_idx] <= 1'b0;
                        if (tamper_in) zero_tamper <= 1'b1;
                        if (zero_idx == SLOT_W'(NUM_SLOTS - 1)) begin
                            if (zero_tamper || tamper_in) state <= S_LOCKED;
                            else if (dna_ok)              state <= S_READY;
                            else                          state <= S_READ;
                        end else begin
                            zero_idx <= zero_idx + 1'b1;
                        end
                    end
                    S_LOCKED: state <= S_LOCKED;
                    default:  state <= S_LOCKED;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_key_vault_mslot.sv
// Self-checking bench for key_vault_mslot: table vectors, hand sequences and random ops vs a model.
module tb_key_vault_mslot;

    localparam logic [56:0]  DNA_A = 57'h1A5_F00D_CAFE_BEEF;
    localparam logic [127:0] K2    = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;
    localparam int           LAT   = 5;

    logic         clk;
    logic         rst;
    logic         dna_read, dna_shift, dna_dout;
    logic [56:0]  golden_dna;
    logic         wr_valid, wr_ready;
    logic [1:0]   wr_slot;
    logic [127:0] wr_key;
    logic         rd_req;
    logic [1:0]   rd_slot;
    logic [127:0] key_out;
    logic         key_valid, key_err;
    logic         tamper_in, zeroize_req;
    logic [2:0]   state_out;
    logic         system_locked;
    logic [3:0]   slot_valid;
    logic [1:0]   fail_count;
    logic [56:0]  device_dna;

    int           n_vec = 0;
    int           n_err = 0;
    logic [56:0]  dev_dna;
    int           port_idx;
    logic [127:0] mdl_key [4];
    bit           mdl_valid [4];

    key_vault_mslot dut (
        .clk(clk), .rst(rst), .dna_read(dna_read), .dna_shift(dna_shift), .dna_dout(dna_dout),
        .golden_dna(golden_dna), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_slot(wr_slot),
        .wr_key(wr_key), .rd_req(rd_req), .rd_slot(rd_slot), .key_out(key_out),
        .key_valid(key_valid), .key_err(key_err), .tamper_in(tamper_in),
        .zeroize_req(zeroize_req), .state_out(state_out), .system_locked(system_locked),
        .slot_valid(slot_valid), .fail_count(fail_count), .device_dna(device_dna)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural DNA_PORT: READ reloads, each SHIFT edge advances, MSB presented first.
    always @(posedge clk) begin
        if (dna_read)       port_idx <= 0;
        else if (dna_shift) port_idx <= port_idx + 1;
    end
    assign dna_dout = (port_idx >= 0 && port_idx < 57) ? dev_dna[56 - port_idx] : 1'b0;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference derivation written per output bit from the mixing rules.
    function automatic logic [127:0] mdl_derive(input logic [127:0] key, input int slot,
                                                input logic [56:0] dna);
        logic [127:0] d, x, y;
        logic [1:0]   sb;
        for (int j = 0; j < 128; j++) d[j] = dna[j % 57];
        sb = slot[1:0];
        x = key ^ d;
        x[127:126] = x[127:126] ^ sb;
        for (int r = 0; r < 4; r++) begin
            for (int j = 0; j < 128; j++) begin
                y[j] = x[(j + 128 - 13) % 128] ^ ((j + 7 < 128) ? x[(j + 7) % 128] : 1'b0)
                       ^ d[j] ^ r[j % 8];
            end
            x = y;
        end
        return x;
    endfunction

    task automatic mdl_clear();
        for (int i = 0; i < 4; i++) begin
            mdl_key[i]   = '0;
            mdl_valid[i] = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; wr_valid = 1'b0; rd_req = 1'b0; tamper_in = 1'b0; zeroize_req = 1'b0;
        wr_slot = '0; rd_slot = '0; wr_key = '0;
        tick(); tick();
        chk("reset_flags", 128'({state_out, system_locked, slot_valid, fail_count, dna_read,
                                 dna_shift, wr_ready, key_valid, key_err}), 128'(0));
        chk("reset_dna_key", 128'(device_dna) | key_out, 128'(0));
        mdl_clear();
        rst = 1'b0;
    endtask

    task automatic bring_up(input logic [56:0] golden, input logic [56:0] dna);
        golden_dna = golden;
        dev_dna    = dna;
        do_reset();
        for (int t = 0; t < 300 && state_out != 3'd2 && state_out != 3'd5; t++) tick();
    endtask

    task automatic do_write(input int s, input logic [127:0] k);
        wr_valid = 1'b1; wr_slot = 2'(s); wr_key = k;
        #1;
        chk("wr_ready", 128'(wr_ready), 128'(1));
        tick();
        wr_valid = 1'b0;
        mdl_key[s]   = k;
        mdl_valid[s] = 1'b1;
    endtask

    task automatic do_read(input int s, input bit ev, input string nm);
        int           vc, ec;
        logic [127:0] ko;
        bit           stray;
        vc = -1; ec = -1; ko = '0; stray = 1'b0;
        rd_req = 1'b1; rd_slot = 2'(s);
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k == 1) rd_req = 1'b0;
            if (key_valid && vc < 0) begin vc = k; ko = key_out; end
            if (!key_valid && key_out != '0) stray = 1'b1;
            if (key_err && ec < 0) ec = k;
        end
        chk({nm, "_valid_cycle"}, 128'(vc), ev ? 128'(LAT) : 128'(-1));
        chk({nm, "_err_cycle"}, 128'(ec), ev ? 128'(-1) : 128'(1));
        if (ev) chk({nm, "_key"}, ko, mdl_derive(mdl_key[s], s, dev_dna));
        chk({nm, "_key_out_idle_zero"}, 128'(stray), 128'(0));
    endtask

    typedef struct {
        bit           is_wr;
        int           slot;
        logic [127:0] key;
        bit           exp_valid;
        logic [3:0]   exp_sv;
    } vec_t;

    vec_t tbl [8];

    initial begin
        int           sc, zc, np, vc;
        bit           sv4, kvs, errs;
        logic [127:0] ko, kr;

        tbl[0] = '{1'b1, 2, K2,              1'b0, 4'b0100};
        tbl[1] = '{1'b0, 2, '0,              1'b1, 4'b0100};
        tbl[2] = '{1'b0, 1, '0,              1'b0, 4'b0100};
        tbl[3] = '{1'b1, 0, ~K2,             1'b0, 4'b0101};
        tbl[4] = '{1'b0, 0, '0,              1'b1, 4'b0101};
        tbl[5] = '{1'b1, 2, 128'hDEAD_BEEF,  1'b0, 4'b0101};
        tbl[6] = '{1'b0, 2, '0,              1'b1, 4'b0101};
        tbl[7] = '{1'b0, 3, '0,              1'b0, 4'b0101};

        // DNA read timing: READ pulse, 57 shifts, one CHECK cycle, then READY.
        golden_dna = DNA_A;
        dev_dna    = DNA_A;
        port_idx   = 0;
        do_reset();
        tick();
        chk("dna_read_pulse", 128'(dna_read), 128'(1));
        sc = 0;
        for (int t = 2; t <= 59; t++) begin
            tick();
            if (dna_shift) sc++;
        end
        chk("dna_shift_cycles", 128'(sc), 128'(57));
        chk("check_state", 128'(state_out), 128'(1));
        tick();
        chk("ready_state", 128'(state_out), 128'(2));
        chk("device_dna", 128'(device_dna), 128'(DNA_A));

        for (int i = 0; i < 8; i++) begin
            if (tbl[i].is_wr) do_write(tbl[i].slot, tbl[i].key);
            else              do_read(tbl[i].slot, tbl[i].exp_valid, $sformatf("tbl%0d", i));
            chk($sformatf("tbl%0d_slot_valid", i), 128'(slot_valid), 128'(tbl[i].exp_sv));
        end

        // Read/write collision: derive first, write lands once READY again.
        wr_valid = 1'b1; wr_slot = 2'd3; wr_key = K2 ^ 128'h5A; rd_req = 1'b1; rd_slot = 2'd2;
        #1;
        chk("coll_wr_ready", 128'(wr_ready), 128'(0));
        vc = -1; sv4 = 1'b1; ko = '0;
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k == 1) rd_req = 1'b0;
            if (key_valid && vc < 0) begin vc = k; ko = key_out; end
            if (k == 4) sv4 = slot_valid[3];
        end
        wr_valid = 1'b0;
        chk("coll_valid_cycle", 128'(vc), 128'(LAT));
        chk("coll_key", ko, mdl_derive(mdl_key[2], 2, dev_dna));
        chk("coll_write_waited", 128'(sv4), 128'(0));
        chk("coll_write_done", 128'(slot_valid[3]), 128'(1));
        mdl_key[3] = K2 ^ 128'h5A; mdl_valid[3] = 1'b1;

        for (int n = 0; n < 30; n++) begin
            int s;
            s = int'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) begin
                kr = {$urandom(), $urandom(), $urandom(), $urandom()};
                do_write(s, kr);
            end else begin
                do_read(s, mdl_valid[s], $sformatf("rnd%0d", n));
            end
            chk($sformatf("rnd%0d_slot_valid", n), 128'(slot_valid),
                128'({mdl_valid[3], mdl_valid[2], mdl_valid[1], mdl_valid[0]}));
        end

        // Software zeroize from READY.
        do_write(0, K2); do_write(2, ~K2);
        zeroize_req = 1'b1;
        tick();
        zeroize_req = 1'b0;
        zc = 0;
        for (int t = 0; t < 20 && state_out == 3'd4; t++) begin zc++; tick(); end
        mdl_clear();
        chk("zeroize_cycles", 128'(zc), 128'(4));
        chk("zeroize_state", 128'(state_out), 128'(2));
        chk("zeroize_slots", 128'(slot_valid), 128'(0));
        do_read(2, 1'b0, "post_zeroize");

        // Tamper two cycles into a derive.
        do_write(2, K2);
        rd_req = 1'b1; rd_slot = 2'd2;
        tick();
        rd_req = 1'b0;
        tick();
        tamper_in = 1'b1;
        zc = 0; kvs = 1'b0;
        for (int t = 0; t < 12; t++) begin
            tick();
            if (state_out == 3'd4) zc++;
            if (key_valid) kvs = 1'b1;
        end
        tamper_in = 1'b0;
        chk("tamper_no_key", 128'(kvs), 128'(0));
        chk("tamper_zero_cycles", 128'(zc), 128'(4));
        chk("tamper_slots", 128'(slot_valid), 128'(0));
        chk("tamper_locked", 128'({state_out, system_locked}), 128'({3'd5, 1'b1}));

        // Locked: writes and reads ignored.
        wr_valid = 1'b1; wr_slot = 2'd1; wr_key = K2; rd_req = 1'b1; rd_slot = 2'd2;
        #1;
        chk("locked_wr_ready", 128'(wr_ready), 128'(0));
        errs = 1'b0;
        for (int t = 0; t < 4; t++) begin
            tick();
            if (key_valid || key_err || key_out != '0) errs = 1'b1;
        end
        wr_valid = 1'b0; rd_req = 1'b0;
        chk("locked_no_response", 128'(errs), 128'(0));
        chk("locked_slots", 128'(slot_valid), 128'(0));

        // Unprovisioned golden accepts any DNA.
        bring_up(57'd0, 57'h0F0_1234_5678_9ABC);
        chk("unprov_state", 128'(state_out), 128'(2));
        chk("unprov_dna", 128'(device_dna), 128'(57'h0F0_1234_5678_9ABC));

        // Repeated mismatch ends in permanent lock after three passes.
        golden_dna = DNA_A;
        dev_dna    = DNA_A ^ 57'h1;
        do_reset();
        np = 0;
        for (int t = 0; t < 400 && !system_locked; t++) begin
            tick();
            if (dna_read) np++;
        end
        chk("lock_passes", 128'(np), 128'(3));
        chk("lock_fail_count", 128'(fail_count), 128'(3));
        chk("lock_state", 128'(state_out), 128'(5));
        wr_valid = 1'b1; wr_slot = 2'd0; wr_key = K2;
        tick(); tick();
        wr_valid = 1'b0;
        chk("lock_write_ignored", 128'(slot_valid), 128'(0));
        chk("lock_dna_not_latched", 128'(device_dna), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
